stream_mux: RTL and testbench

Registered N-way stream multiplexer with valid/ready handshakes. It generalises the plain 5-input select mux to N channels of any width and registers the output. Selection comes from an explicit select port or, when compiled in, a round-robin arbiter. It sits between multiple producers (ALU result, load data, PC+4, immediate, CSR/debug sources) and a single downstream consumer stage, where a stall-aware single-beat buffer is needed.

---
 rtl/stream_mux.sv | 108 ++++++++++
 tb/tb_stream_mux.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/stream_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_mux : registered N-way valid/ready stream multiplexer; optional
// round-robin selection when STREAM_MUX_RR_EN is defined.   Rev 1.0
// ---------------------------------------------------------------------------
module stream_mux #(
  parameter  int WIDTH = 32,
  parameter  int N     = 5,
  localparam int SW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SW-1:0]      sel,
  input  logic               mode,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_grant,
  input  logic               out_ready
);

  localparam logic [SW:0] c_n = (SW+1)'(N);

  logic             w_load_en;
  logic             w_have;
  logic             w_xfer;
  logic [SW-1:0]    w_c;
  logic [SW-1:0]    w_sel_c;
  logic [WIDTH-1:0] w_data;

  // Gated by rst_n so nothing is handshaken while the block is held in reset.
  assign w_load_en = rst_n & (~out_valid | out_ready);
  assign w_sel_c   = ({1'b0, sel} < c_n) ? sel : '0;

`ifdef STREAM_MUX_RR_EN
  logic [SW-1:0] r_ptr;
  logic [SW-1:0] w_rr_c;
  logic          w_rr_found;

  function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return s[SW-1:0];
  endfunction

  // Scan farthest-first so the nearest valid channel after ptr wins.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_c     = '0;
    for (int k = N; k >= 1; k--) begin
      if (in_valid[wrap_idx(r_ptr, k)]) begin
        w_rr_found = 1'b1;
        w_rr_c     = wrap_idx(r_ptr, k);
      end
    end
  end

  assign w_c    = mode ? w_rr_c : w_sel_c;
  assign w_have = mode ? w_rr_found : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= SW'(N-1);
    end else if (w_xfer && mode) begin
      r_ptr <= w_c;
    end
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  assign w_c           = w_sel_c;
  assign w_have        = 1'b1;
`endif

  assign w_xfer = w_load_en & w_have & in_valid[w_c];

  for (genvar i = 0; i < N; i++) begin : g_ready
    assign in_ready[i] = w_load_en & w_have & (w_c == SW'(i));
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_c == SW'(i)) w_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
    end else if (w_load_en) begin
      if (w_xfer) begin
        out_valid <= 1'b1;
        out_data  <= w_data;
        out_grant <= w_c;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_mux.sv
`default_nettype none
// Scoreboard bench for stream_mux (N=5, WIDTH=32); RR vectors run only when
// STREAM_MUX_RR_EN is defined.
module tb_stream_mux;
  localparam int WIDTH = 32;
  localparam int N     = 5;
  localparam int SW    = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [SW-1:0]      sel;
  logic               mode;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SW-1:0]      out_grant;
  logic               out_ready;

  logic [WIDTH-1:0]         dat [N];
  logic [SW+WIDTH-1:0]      exp_q [$];
  int vectors = 0;
  int errors  = 0;

  stream_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_grant(out_grant),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = dat[i];
  end

  // Monitor: a beat leaves on the next rising edge whenever valid & ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [SW+WIDTH-1:0] e;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: unexpected beat grant=%0d data=%h, none expected", out_grant, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_grant, out_data} !== e) begin
          errors++;
          $display("FAIL beat: got grant=%0d data=%h, expected grant=%0d data=%h",
                   out_grant, out_data, e[SW+WIDTH-1:WIDTH], e[WIDTH-1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check in_ready/out_valid, queue the expected beat.
  task automatic step(input logic [SW-1:0] s, input logic m, input logic [N-1:0] v,
                      input logic ordy, input logic exp_ov, input logic [N-1:0] exp_rdy,
                      input bit push, input logic [SW-1:0] eg);
    sel = s; mode = m; in_valid = v; out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (push) exp_q.push_back({eg, dat[eg]});
    @(posedge clk); #2;
  endtask

  initial begin
    for (int i = 0; i < N; i++) dat[i] = 32'h1000_0000 + i;
    rst_n = 1'b0; sel = 3'd3; mode = 1'b0; in_valid = 5'b11111; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_grant", 32'(out_grant), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    #1 rst_n = 1'b1;

    step(3, 0, 5'b11111, 1, 0, 5'b01000, 1, 3);
    dat[1] = 32'hAAAA_0001;
    step(1, 0, 5'b11111, 1, 1, 5'b00010, 1, 1);
    repeat (4) step(1, 0, 5'b11111, 0, 1, 5'b00000, 0, 0);
    dat[1] = 32'h0000_BBBB;
    step(2, 0, 5'b11111, 0, 1, 5'b00000, 0, 0);
    step(2, 0, 5'b11111, 1, 1, 5'b00100, 1, 2);

    for (int k = 0; k < 3; k++) begin
      dat[4] = 32'(10 + k);
      step(4, 0, 5'b10000, 1, 1, 5'b10000, 1, 4);
    end

    dat[0] = 32'h55;
    step(7, 0, 5'b00001, 1, 1, 5'b00001, 1, 0);
    step(0, 0, 5'b00000, 1, 1, 5'b00001, 0, 0);
    step(2, 0, 5'b11011, 1, 0, 5'b00100, 0, 0);

    // Beat loaded then held at reset must vanish.
    dat[1] = 32'h77;
    step(1, 0, 5'b00010, 1, 0, 5'b00010, 0, 0);
    step(1, 0, 5'b00010, 0, 1, 5'b00000, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_data", out_data, 0);
    in_valid = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;

`ifdef STREAM_MUX_RR_EN
    step(0, 1, 5'b10110, 1, 0, 5'b00010, 1, 1);
    step(0, 1, 5'b10110, 1, 1, 5'b00100, 1, 2);
    step(0, 1, 5'b10110, 1, 1, 5'b10000, 1, 4);
    step(0, 1, 5'b10110, 1, 1, 5'b00010, 1, 1);
    step(0, 1, 5'b10110, 1, 1, 5'b00100, 1, 2);
    step(0, 1, 5'b10110, 1, 1, 5'b10000, 1, 4);
    step(0, 1, 5'b00000, 1, 1, 5'b00000, 0, 0);
    step(0, 1, 5'b10110, 1, 0, 5'b00010, 1, 1);
    step(0, 1, 5'b10110, 0, 1, 5'b00000, 0, 0);
    step(0, 1, 5'b10110, 0, 1, 5'b00000, 0, 0);
    step(0, 1, 5'b10110, 1, 1, 5'b00100, 1, 2);
    repeat (3) step(0, 1, 5'b01000, 1, 1, 5'b01000, 1, 3);
    step(0, 1, 5'b00000, 1, 1, 5'b00000, 0, 0);
    step(0, 1, 5'b00000, 1, 0, 5'b00000, 0, 0);
`endif

    step(0, 0, 5'b00000, 1, 0, 5'b00001, 0, 0);
    repeat (2) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire
